// File: rtl/r3_pkg.sv
// Shared types and sizes for the radix-3^2 triplet gather block.
// One complex sample is a packed {re, img} pair of DW-bit two's complement values.
package r3_pkg;
  localparam int DW    = 32;
  localparam int N     = 9;
  localparam int NBANK = 2;
  localparam int AW    = 4;

  typedef logic [1:0] tri_idx_t;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] img;
  } cplx_t;

  function automatic logic is_last_addr(input logic [AW-1:0] addr);
    return addr == AW'(N - 1);
  endfunction
endpackage

// File: rtl/r3_bank.sv
// Nine-entry complex register file: one synchronous write port and three
// combinational read ports returning x[k], x[k+3] and x[k+6].
module r3_bank
  import r3_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cplx_t         wdata,
  input  tri_idx_t      rd_k,
  output cplx_t         rd_a,
  output cplx_t         rd_b,
  output cplx_t         rd_c
);
  cplx_t         mem_reg [N];
  logic [AW-1:0] idx_a;
  logic [AW-1:0] idx_b;
  logic [AW-1:0] idx_c;

  // Contents are never reset: a frame is only read after all nine entries are rewritten.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (we && waddr == AW'(gi)) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign idx_a = {2'b00, rd_k};
  assign idx_b = idx_a + AW'(3);
  assign idx_c = idx_a + AW'(6);

  assign rd_a = mem_reg[idx_a];
  assign rd_b = mem_reg[idx_b];
  assign rd_c = mem_reg[idx_c];
endmodule

// File: rtl/r3_triplet_gather.sv
// Ping-pong frame buffer: collects nine serial complex samples per bank and
// replays each full bank as three butterfly triplets (x[k], x[k+3], x[k+6]).
module r3_triplet_gather
  import r3_pkg::*;
#(
  parameter int DW = 32,
  parameter int N  = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          in_ready,
  output logic [DW-1:0] a_re,
  output logic [DW-1:0] b_re,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] a_img,
  output logic [DW-1:0] b_img,
  output logic [DW-1:0] c_img,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_k,
  output logic          out_last
);
  logic [NBANK-1:0] full_reg;
  logic [NBANK-1:0] full_next;
  logic             wr_bank_reg;
  logic [AW-1:0]    wr_cnt_reg;
  logic             rd_bank_reg;
  tri_idx_t         rd_k_reg;
  logic             out_valid_reg;
  tri_idx_t         out_k_reg;
  logic             out_last_reg;
  cplx_t            a_reg;
  cplx_t            b_reg;
  cplx_t            c_reg;

  logic             accept;
  logic             load;
  logic             wr_done;
  logic             rd_done;
  cplx_t            wdata;
  cplx_t            rd_a [NBANK];
  cplx_t            rd_b [NBANK];
  cplx_t            rd_c [NBANK];

  assign in_ready = !rst && !full_reg[wr_bank_reg];
  assign accept   = in_valid && in_ready;
  assign load     = (!out_valid_reg || out_ready) && full_reg[rd_bank_reg];
  assign wr_done  = accept && is_last_addr(wr_cnt_reg);
  assign rd_done  = load && (rd_k_reg == 2'd2);
  assign wdata    = '{re: in_re, img: in_img};

  // Set and clear can never hit the same bank on one edge: the writer only
  // targets an empty bank while the reader only drains a full one.
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      r3_bank u_bank (
        .clk   (clk),
        .we    (accept && (wr_bank_reg == 1'(gi))),
        .waddr (wr_cnt_reg),
        .wdata (wdata),
        .rd_k  (rd_k_reg),
        .rd_a  (rd_a[gi]),
        .rd_b  (rd_b[gi]),
        .rd_c  (rd_c[gi])
      );

      assign full_next[gi] = (full_reg[gi] || (wr_done && wr_bank_reg == 1'(gi)))
                             && !(rd_done && rd_bank_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg      <= '0;
      wr_bank_reg   <= 1'b0;
      wr_cnt_reg    <= '0;
      rd_bank_reg   <= 1'b0;
      rd_k_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_k_reg     <= '0;
      out_last_reg  <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
    end else begin
      full_reg <= full_next;

      if (accept) begin
        if (wr_done) begin
          wr_cnt_reg  <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + AW'(1);
        end
      end

      if (load) begin
        a_reg         <= rd_a[rd_bank_reg];
        b_reg         <= rd_b[rd_bank_reg];
        c_reg         <= rd_c[rd_bank_reg];
        out_k_reg     <= rd_k_reg;
        out_last_reg  <= rd_done;
        out_valid_reg <= 1'b1;
        if (rd_done) begin
          rd_k_reg    <= '0;
          rd_bank_reg <= ~rd_bank_reg;
        end else begin
          rd_k_reg <= rd_k_reg + 2'd1;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign a_re      = a_reg.re;
  assign b_re      = b_reg.re;
  assign c_re      = c_reg.re;
  assign a_img     = a_reg.img;
  assign b_img     = b_reg.img;
  assign c_img     = c_reg.img;
  assign out_valid = out_valid_reg;
  assign out_k     = out_k_reg;
  assign out_last  = out_last_reg;
endmodule

// File: tb/tb_r3_triplet_gather.sv
// Scoreboard bench for r3_triplet_gather: stimulus pushes expected triplets,
// an independent negedge monitor pops and compares them on each handshake.
module tb_r3_triplet_gather;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_img = '0;
  logic          in_ready;
  logic [DW-1:0] a_re, b_re, c_re, a_img, b_img, c_img;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_k;
  logic          out_last;

  r3_triplet_gather #(.DW(DW), .N(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_img    (in_img),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .b_re      (b_re),
    .c_re      (c_re),
    .a_img     (a_img),
    .b_img     (b_img),
    .c_img     (c_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_k     (out_k),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] ar, br, cr, ai, bi, ci;
    logic [1:0]    k;
    logic          last;
  } trip_t;

  trip_t         sb[$];
  logic [DW-1:0] fre [9];
  logic [DW-1:0] fim [9];
  int            fcnt = 0;
  int            tests = 0;
  int            fails = 0;
  logic          ready_cmd = 1'b1;
  logic          rand_ready = 1'b0;
  logic          rand_valid = 1'b0;

  function automatic void check(input string nm, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: every complete frame of nine samples yields three triplets.
  task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im);
    trip_t t;
    fre[fcnt] = re;
    fim[fcnt] = im;
    fcnt++;
    if (fcnt == 9) begin
      for (int k = 0; k < 3; k++) begin
        t.ar = fre[k]; t.br = fre[k+3]; t.cr = fre[k+6];
        t.ai = fim[k]; t.bi = fim[k+3]; t.ci = fim[k+6];
        t.k = 2'(k);
        t.last = (k == 2);
        sb.push_back(t);
      end
      fcnt = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, output int stalls);
    stalls = 0;
    if (rand_valid && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_re = re;
    in_img = im;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      stalls++;
      if (stalls > 500) begin
        $display("FAIL in_ready_timeout: got stalled %0d cycles expected acceptance", stalls);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    model_accept(re, im);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 200'(sb.size()), 200'(0));
  endtask

  task automatic set_ready(input logic v);
    ready_cmd = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Sole driver of out_ready.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  // Monitor: compares each accepted triplet against the scoreboard and checks
  // that a stalled output holds every field until it is taken.
  initial begin
    logic [199:0] vec;
    logic [199:0] prev_vec = '0;
    logic         prev_stall = 1'b0;
    trip_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        vec = {a_re, b_re, c_re, a_img, b_img, c_img, out_k, out_last, 5'b0};
        if (prev_stall && out_valid) check("hold", vec, prev_vec);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_triplet: got k=%0d a_re=%h expected no output", out_k, a_re);
          end else begin
            e = sb.pop_front();
            $display("[TB] triplet k=%0d last=%0d re=(%h,%h,%h) img=(%h,%h,%h)",
                     out_k, out_last, a_re, b_re, c_re, a_img, b_img, c_img);
            check("triplet", vec, {e.ar, e.br, e.cr, e.ai, e.bi, e.ci, e.k, e.last, 5'b0});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_vec = vec;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int st;
    int total_st;
    int idx;
    logic rdy;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 200'(in_ready), 200'(0));
    check("rst_out_valid", 200'(out_valid), 200'(0));
    check("rst_k_last", 200'({out_k, out_last}), 200'(0));
    check("rst_data", 200'({a_re, b_re, c_re, a_img, b_img, c_img}), 200'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 200'(in_ready), 200'(1));
    @(posedge clk); #1;

    // Single frame, latency of one cycle after sample 8
    for (int i = 0; i < 9; i++) send(32'(i), 32'(100 + i), st);
    in_valid = 1'b0;
    check("latency_not_yet", 200'(out_valid), 200'(0));
    @(posedge clk); #1;
    check("latency_valid", 200'(out_valid), 200'(1));
    check("latency_k0", 200'({out_k, a_re, b_re, c_re}), 200'({2'd0, 32'd0, 32'd3, 32'd6}));
    drain();

    // Two back-to-back frames with no input stalls
    total_st = 0;
    for (int i = 0; i < 18; i++) begin
      send(32'(i), 32'(100 + i), st);
      total_st += st;
    end
    check("b2b_no_stall", 200'(total_st), 200'(0));
    drain();

    // Output blocked for 30 cycles while three frames are offered
    set_ready(1'b0);
    idx = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_re = 32'(idx);
      in_img = 32'(100 + idx);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        model_accept(32'(idx), 32'(100 + idx));
        idx++;
      end
    end
    @(negedge clk);
    check("bp_accepted", 200'(idx), 200'(18));
    check("bp_in_ready_low", 200'(in_ready), 200'(0));
    check("bp_hold_036", 200'({out_valid, out_k, a_re, b_re, c_re}), 200'({1'b1, 2'd0, 32'd0, 32'd3, 32'd6}));
    ready_cmd = 1'b1;
    for (int i = 18; i < 27; i++) send(32'(i), 32'(100 + i), st);
    drain();

    // Reset mid-frame discards partial data
    for (int i = 0; i < 5; i++) send(32'(50 + i), 32'(150 + i), st);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 200'(in_ready), 200'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    fcnt = 0;
    sb.delete();
    for (int i = 0; i < 9; i++) send(32'(20 + i), 32'(120 + i), st);
    drain();

    // Negative values pass bit-exact
    for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF, 32'hFFFF_8000, st);
    drain();

    // Random handshakes on both sides
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 9; i++) send($urandom, $urandom, st);
    end
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    drain();
    check("final_partial", 200'(fcnt), 200'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/r3_triplet_gather.md
R3_TRIPLET_GATHER -- requirements
Module: r3_triplet_gather

Interface
REQ-001 Parameter DW, 32, real/imaginary sample width in bits (two's complement).
REQ-002 Parameter N, 9, points per frame; fixed radix-3^2 size; other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  in_re/in_img carry a valid sample.
REQ-006 in_re, in_img  input  DW each  serial complex sample, natural order x[0..8].
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 a_re, b_re, c_re, a_img, b_img, c_img  output  DW each  registered butterfly triplet for the downstream negedge buffer.
REQ-009 out_valid  output  1  triplet outputs are valid.
REQ-010 out_ready  input  1  downstream takes the triplet this cycle.
REQ-011 out_k  output  2  triplet index k within the frame, 0..2.
REQ-012 out_last  output  1  high with triplet k=2.

Function
REQ-013 A sample is accepted on a rising edge with in_valid && in_ready; it is written to wr_bank at address wr_cnt (0..8), and wr_cnt then increments.
REQ-014 Accepting the sample at wr_cnt=8: mark wr_bank full, clear wr_cnt, toggle wr_bank; all in the same edge.
REQ-015 in_ready = NOT(bank[wr_bank] full), from registered state only; low when both banks are full.
REQ-016 Triplet k of a full bank: a=x[k], b=x[k+3], c=x[k+6], emitted in order k=0,1,2.
REQ-017 The output register loads the next triplet on an edge where (!out_valid || out_ready) and bank[rd_bank] is full; out_valid is then set.
REQ-018 Latency: if sample 8 is accepted at edge E, triplet 0 is loaded and out_valid rises at edge E+1.
REQ-019 While out_valid && !out_ready, all outputs hold their values.
REQ-020 On the edge that loads k=2: clear bank[rd_bank] full and toggle rd_bank; that bank may be written from the next edge onward.
REQ-021 out_valid clears on an edge with out_ready and no triplet available to load.
REQ-022 Sustained in_valid with out_ready=1 gives zero input stalls; the output duty cycle is 3 triplets per 9 input cycles.
REQ-023 Data passes bit-exact: no arithmetic, no sign change, no truncation.
REQ-024 The wr_cnt=8 acceptance edge may coincide with a release edge on the other bank; both state updates take effect.

Reset
REQ-025 When rst=1 at an edge: wr_cnt=0, wr_bank=0, rd_bank=0, rd_k=0, both banks empty, out_valid=0, out_k=0, out_last=0, all data outputs=0.
REQ-026 A reset mid-frame or mid-readout discards partial and unread frames; bank contents need not be cleared.
REQ-027 While rst=1, in_ready is forced to 0.

Structure
REQ-028 Package r3_pkg holds DW, N=9, NBANK=2, the complex sample struct {re, img}, and the triplet index type (2 bits).
REQ-029 Sub-module r3_bank is the 9-entry complex register file: one write port and three combinational read ports (k, k+3, k+6). It is instantiated twice.
REQ-030 The block contains no latches, no negedge logic, and no combinational path from in_valid to in_ready.

Verification
REQ-031 Nine samples re=i, img=100+i (i=0..8) with out_ready=1 -> triplets (0,3,6)/(100,103,106), (1,4,7), (2,5,8); out_valid rises 1 cycle after sample 8; out_last only on k=2.
REQ-032 Two back-to-back frames with continuous in_valid -> in_ready stays 1 throughout; 6 triplets arrive in order; frame 2 begins with (9,12,15) when frame 2 carries re=9..17.
REQ-033 out_ready=0 for 30 cycles while three frames are offered -> in_ready drops after the 18th sample, and the outputs hold triplet (0,3,6) unchanged.
REQ-034 rst pulse after 5 samples, then a fresh frame re=20..28 -> first triplet is (20,23,26); no residue from the earlier samples.
REQ-035 Negative values: re=-1, img=-32768 on all samples -> outputs bit-identical to the inputs (0xFFFFFFFF, 0xFFFF8000).
REQ-036 Random in_valid/out_ready at 50% duty over 1000 frames -> scoreboard matches the REQ-016 mapping exactly, with no drops or duplicates.
